seven_segment_reader: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/seg_to_digit.sv | 29 ++
 rtl/seven_segment_reader.sv | 159 +++++++++++++++
 tb/tb_seven_segment_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment bus reader: segment patterns, digit codes, pin order.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [3:0] DIG_BLANK = 4'hE;
  localparam logic [3:0] DIG_BAD   = 4'hF;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  typedef enum logic {
    OUT_IDLE,
    OUT_BUSY
  } out_state_e;

endpackage

// File: rtl/seg_to_digit.sv
// Combinational decode of a 7-bit segment pattern (a..g) into a digit code, blank or bad.
module seg_to_digit
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit
);

  logic [6:0] pat;

  always_comb begin
    pat = {seg[SEG_A], seg[SEG_B], seg[SEG_C], seg[SEG_D], seg[SEG_E], seg[SEG_F], seg[SEG_G]};
    case (pat)
      SEG_0:      digit = 4'd0;
      SEG_1:      digit = 4'd1;
      SEG_2:      digit = 4'd2;
      SEG_3:      digit = 4'd3;
      SEG_4:      digit = 4'd4;
      SEG_5:      digit = 4'd5;
      SEG_6:      digit = 4'd6;
      SEG_7:      digit = 4'd7;
      SEG_8:      digit = 4'd8;
      SEG_9:      digit = 4'd9;
      7'b0000000: digit = DIG_BLANK;
      default:    digit = DIG_BAD;
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a scanned 7-segment bus back into debounced {position, digit} change events.
// Define SEVEN_SEG_READER_ACTIVE_LOW_EN for common-anode boards (inputs inverted before sync).
module seven_segment_reader
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MATCH_COUNT   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [6:0]                    seg_in,
  input  logic [NUM_DIGITS-1:0]         sel_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_DIGITS)-1:0] out_idx,
  output logic [3:0]                    out_digit,
  output logic                          sel_err
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MCH_W = $clog2(MATCH_COUNT + 1);

  logic [6:0]            seg_raw, seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0] sel_raw, sel_s1, sel_s2, sel_prev;
  logic [CNT_W-1:0]      settle_cnt;
  logic                  stable, fire, sel_onehot, sel_multi, sample_en;
  logic [IDX_W-1:0]      sample_idx, pend_idx;
  logic [3:0]            code;
  logic                  hit, commit, launch;
  logic [MCH_W-1:0]      match_nxt;
  logic [NUM_DIGITS-1:0] dirty, dirty_set, dirty_clr;
  logic [3:0]            cand      [NUM_DIGITS];
  logic [MCH_W-1:0]      match     [NUM_DIGITS];
  logic [3:0]            committed [NUM_DIGITS];
  out_state_e            out_state;

`ifdef SEVEN_SEG_READER_ACTIVE_LOW_EN
  assign seg_raw = ~seg_in;
  assign sel_raw = ~sel_in;
`else
  assign seg_raw = seg_in;
  assign sel_raw = sel_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      seg_prev <= '0;
      sel_s1   <= '0;
      sel_s2   <= '0;
      sel_prev <= '0;
    end else begin
      seg_s1   <= seg_raw;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      sel_s1   <= sel_raw;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
    end
  end

  // Sampling on the 0->SETTLE transition gives exactly one sample per stable window.
  assign stable     = (seg_s2 == seg_prev) && (sel_s2 == sel_prev);
  assign fire       = stable && (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign sel_onehot = (sel_s2 != '0) && ((sel_s2 & (sel_s2 - 1'b1)) == '0);
  assign sel_multi  = (sel_s2 != '0) && !sel_onehot;
  assign sample_en  = fire && sel_onehot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      sel_err    <= 1'b0;
    end else begin
      if (!stable)
        settle_cnt <= '0;
      else if (settle_cnt != CNT_W'(SETTLE_CYCLES))
        settle_cnt <= settle_cnt + 1'b1;
      if (fire && sel_multi)
        sel_err <= 1'b1;
    end
  end

  always_comb begin
    sample_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (sel_s2[i]) sample_idx = IDX_W'(i);
  end

  seg_to_digit u_dec (
    .seg   (seg_s2),
    .digit (code)
  );

  always_comb begin
    hit       = (code == cand[sample_idx]);
    match_nxt = !hit ? MCH_W'(1) :
                (match[sample_idx] == MCH_W'(MATCH_COUNT)) ? match[sample_idx] :
                match[sample_idx] + 1'b1;
    commit    = sample_en && (match_nxt == MCH_W'(MATCH_COUNT)) && (code != committed[sample_idx]);
    dirty_set = '0;
    if (commit) dirty_set[sample_idx] = 1'b1;
  end

  always_comb begin
    pend_idx = '0;
    for (int unsigned i = NUM_DIGITS; i > 0; i--)
      if (dirty[i-1]) pend_idx = IDX_W'(i - 1);
    launch    = (out_state == OUT_IDLE) && (dirty != '0);
    dirty_clr = '0;
    if (launch) dirty_clr[pend_idx] = 1'b1;
  end

  // A commit landing on the position being launched re-arms its dirty bit (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        cand[i]      <= DIG_BLANK;
        match[i]     <= '0;
        committed[i] <= DIG_BLANK;
      end
      dirty <= '0;
    end else begin
      if (sample_en) begin
        cand[sample_idx]  <= code;
        match[sample_idx] <= match_nxt;
        if (commit) committed[sample_idx] <= code;
      end
      dirty <= (dirty & ~dirty_clr) | dirty_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state <= OUT_IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_digit <= '0;
    end else begin
      case (out_state)
        OUT_IDLE:
          if (launch) begin
            out_state <= OUT_BUSY;
            out_valid <= 1'b1;
            out_idx   <= pend_idx;
            out_digit <= committed[pend_idx];
          end
        OUT_BUSY:
          if (out_ready) begin
            out_state <= OUT_IDLE;
            out_valid <= 1'b0;
          end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Randomized scenario bench for seven_segment_reader against a window-level behavioural model.
module tb_seven_segment_reader;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;
  localparam int unsigned MC = 3;

  typedef struct packed {
    logic [7:0] pos;
    logic [3:0] code;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    seg_in;
  logic [ND-1:0] sel_in;
  logic          out_valid, out_ready;
  logic [1:0]    out_idx;
  logic [3:0]    out_digit;
  logic          sel_err;

  int checks = 0;
  int errors = 0;

  logic [6:0] pat_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  int  m_committed [ND];
  int  m_last      [ND];
  int  m_run       [ND];
  ev_t exp_q [$];
  ev_t got_q [$];

  always #5 clk = ~clk;

  seven_segment_reader #(
    .NUM_DIGITS    (ND),
    .SETTLE_CYCLES (SC),
    .MATCH_COUNT   (MC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .sel_in    (sel_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_digit (out_digit),
    .sel_err   (sel_err)
  );

  always @(negedge clk) begin
    ev_t e;
    if (!reset && out_valid && out_ready) begin
      e.pos  = 8'(out_idx);
      e.code = out_digit;
      got_q.push_back(e);
    end
  end

  function automatic int ref_decode(logic [6:0] p);
    for (int d = 0; d < 10; d++)
      if (p == pat_tab[d]) return d;
    if (p == 7'b0000000) return 14;
    return 15;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ND; i++) begin
      m_committed[i] = 14;
      m_last[i]      = 14;
      m_run[i]       = 0;
    end
  endfunction

  // One sample of a position: commit once MC identical codes in a row differ from the committed one.
  function automatic void model_sample(int pos, logic [6:0] p);
    int  c;
    ev_t e;
    c = ref_decode(p);
    if (c == m_last[pos]) m_run[pos]++;
    else begin
      m_last[pos] = c;
      m_run[pos]  = 1;
    end
    if (m_run[pos] >= MC && c != m_committed[pos]) begin
      m_committed[pos] = c;
      e.pos  = 8'(pos);
      e.code = 4'(c);
      exp_q.push_back(e);
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pins(input logic [ND-1:0] s, input logic [6:0] p);
`ifdef SEVEN_SEG_READER_ACTIVE_LOW_EN
    sel_in = ~s;
    seg_in = ~p;
`else
    sel_in = s;
    seg_in = p;
`endif
  endtask

  task automatic scan(input int pos, input logic [6:0] p, input int hold);
    logic [ND-1:0] s;
    s = '0;
    s[pos] = 1'b1;
    set_pins(s, p);
    cyc(hold);
    if (hold >= int'(SC) + 1) model_sample(pos, p);
    set_pins('0, 7'b0000000);
    cyc(2);
  endtask

  function automatic int rnd_hold();
    return int'($urandom_range(SC + 6, SC + 2));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    set_pins('0, 7'b0000000);
    cyc(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    checks++; if (out_digit !== 4'd0) begin errors++; $display("FAIL reset_digit got %h want 0", out_digit); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    reset = 1'b0;
    model_reset();
    cyc(SC + 8);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single_digit();
    int first;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    scan(0, 7'b1111001, rnd_hold());
    scan(0, 7'b1111001, rnd_hold());
    set_pins(4'b0001, 7'b1111001);
    first = -1;
    for (int n = 1; n <= int'(SC) + 10; n++) begin
      cyc(1);
      if (out_valid === 1'b1 && first < 0) first = n;
    end
    model_sample(0, 7'b1111001);
    set_pins('0, 7'b0000000);
    cyc(2);
    checks++;
    if (first < int'(SC) + 3 || first > int'(SC) + 5) begin
      errors++; $display("FAIL single_latency got %0d want %0d..%0d", first, SC + 3, SC + 5);
    end
    checks++;
    if (exp_q.size() != 1 || out_idx !== exp_q[0].pos[1:0] || out_digit !== exp_q[0].code) begin
      errors++; $display("FAIL single_present got %0d/%h model_events %0d", out_idx, out_digit, exp_q.size());
    end
    out_ready = 1'b1;
    cyc(8);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL single_event got %h want %h", got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    int  vals [ND] = '{1, 2, 7, 0};
    ev_t want [$];
    ev_t first;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int p = 0; p < int'(ND); p++)
        scan(p, pat_tab[vals[p]], rnd_hold());
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL bp_model got 0 events want >0");
    end else begin
      // First commit is presented at once; the rest drain by ascending position, latest value.
      first = exp_q[0];
      want.push_back(first);
      for (int p = 0; p < int'(ND); p++) begin
        int last_k = -1;
        for (int k = 1; k < exp_q.size(); k++)
          if (int'(exp_q[k].pos) == p) last_k = k;
        if (last_k >= 0) want.push_back(exp_q[last_k]);
      end
      for (int n = 0; n < 5; n++) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== first.pos[1:0] || out_digit !== first.code) begin
          errors++; $display("FAIL bp_hold got v=%b %0d/%h want v=1 %0d/%h", out_valid, out_idx, out_digit, first.pos, first.code);
        end
        cyc(1);
      end
    end
    out_ready = 1'b1;
    cyc(14);
    checks++;
    if (got_q.size() != want.size()) begin
      errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), want.size());
    end else foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== want[k]) begin errors++; $display("FAIL bp_event got %h want %h", got_q[k], want[k]); end
    end
  endtask

  task automatic test_alternate();
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      scan(2, (s % 2 == 0) ? pat_tab[8] : pat_tab[9], rnd_hold());
      scan(1, pat_tab[2], rnd_hold());
    end
    cyc(6);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL alt_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL alt_event got %h want %h", got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_glitch();
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) scan(3, pat_tab[8], int'(SC) - 1);
    cyc(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL glitch_short got %0d events want %0d", got_q.size(), exp_q.size());
    end
    for (int s = 0; s < 3; s++) begin
      set_pins(4'b1000, pat_tab[8]);
      cyc(2);
      set_pins(4'b1000, pat_tab[5]);
      cyc(SC + 3);
      model_sample(3, pat_tab[5]);
      set_pins('0, 7'b0000000);
      cyc(2);
    end
    cyc(6);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL glitch_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL glitch_event got %h want %h", got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_multi_hot();
    logic exp_err;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    exp_err = 1'b0;
    checks++; if (sel_err !== exp_err) begin errors++; $display("FAIL mh_pre got %b want %b", sel_err, exp_err); end
    set_pins(4'b0101, pat_tab[5]);
    cyc(10);
    exp_err = 1'b1;
    set_pins('0, 7'b0000000);
    cyc(4);
    checks++; if (sel_err !== exp_err) begin errors++; $display("FAIL mh_err got %b want %b", sel_err, exp_err); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mh_no_event got %0d want 0", got_q.size()); end
    for (int s = 0; s < 3; s++) scan(0, pat_tab[9], rnd_hold());
    cyc(6);
    checks++; if (sel_err !== exp_err) begin errors++; $display("FAIL mh_sticky got %b want %b", sel_err, exp_err); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mh_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL mh_event got %h want %h", got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    logic [6:0] vals [ND];
    int         r;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int p = 0; p < int'(ND); p++) begin
        if (s == 0 || $urandom_range(2, 0) == 0) begin
          r = int'($urandom_range(11, 0));
          if (r < 10) vals[p] = pat_tab[r];
          else if (r == 10) vals[p] = 7'b0000000;
          else vals[p] = 7'($urandom_range(127, 0));
        end
        scan(p, vals[p], rnd_hold());
      end
    end
    cyc(6);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_event got %h want %h", got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_bad_reset();
    int n;
    out_ready = 1'b1;
    if (m_committed[1] == 15) begin
      for (int s = 0; s < 3; s++) scan(1, pat_tab[6], rnd_hold());
      cyc(6);
    end
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) scan(1, 7'b0100100, rnd_hold());
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bad_valid got %b want 1", out_valid); end
    checks++;
    if (exp_q.size() != 1 || out_idx !== exp_q[0].pos[1:0] || out_digit !== exp_q[0].code) begin
      errors++; $display("FAIL bad_present got %0d/%h model_events %0d", out_idx, out_digit, exp_q.size());
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", out_valid); end
    checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL async_idx got %0d want 0", out_idx); end
    checks++; if (out_digit !== 4'd0) begin errors++; $display("FAIL async_digit got %h want 0", out_digit); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL async_sel_err got %b want 0", sel_err); end
    cyc(2);
    reset = 1'b0;
    model_reset();
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) scan(1, 7'b0000000, rnd_hold());
    for (int s = 0; s < 3; s++) scan(0, 7'b0000000, rnd_hold());
    cyc(6);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL post_reset_blank got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int s = 0; s < 3; s++) scan(1, pat_tab[6], rnd_hold());
    cyc(6);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL post_reset_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL post_reset_event got %h want %h", got_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    set_pins('0, 7'b0000000);
    test_reset();
    test_single_digit();
    test_backpressure();
    test_alternate();
    test_glitch();
    test_multi_hot();
    test_random();
    test_bad_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
